// File: rtl/usb_frame_rx.sv
// usb_frame_rx: serial frame receiver with a glitch-filtered serial clock, an inter-bit
// watchdog, per-frame parity/framing flags and a first-word-fall-through output FIFO.
module usb_frame_rx #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 1,
    parameter int FILTER_LEN = 4,
    parameter int TIMEOUT    = 4000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              ck,
    input  logic                              reset,
    input  logic                              ser_clk,
    input  logic                              ser_data,
    input  logic                              rd,
    output logic [DATA_BITS-1:0]              rd_data,
    output logic                              rd_par_err,
    output logic                              rd_frm_err,
    output logic                              empty,
    output logic                              full,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   count,
    output logic                              busy,
    output logic                              overrun,
    output logic                              timeout
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int EW = DATA_BITS + 2;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]           clk_sync, dat_sync;
    logic                 filt;
    logic [FW-1:0]        fcnt;
    logic                 bit_ev, sample;
    state_t               state, state_n;
    logic [BW-1:0]        bitcnt, bitcnt_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 perr, perr_n;
    logic [TW-1:0]        tcnt, tcnt_n;
    logic                 push, tmo_hit;
    logic [EW-1:0]        mem [FIFO_DEPTH];
    logic [EW-1:0]        head;
    logic [AW-1:0]        wptr, rptr;
    logic [CW-1:0]        cnt;
    logic                 do_rd, do_wr;

    // The filtered level only follows the synchronized clock after FILTER_LEN steady cycles.
    always_ff @(posedge ck) begin
        if (!reset) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            filt     <= 1'b1;
            fcnt     <= '0;
        end else begin
            clk_sync <= {clk_sync[0], ser_clk};
            dat_sync <= {dat_sync[0], ser_data};
            if (clk_sync[1] == filt)
                fcnt <= '0;
            else if (fcnt == FW'(FILTER_LEN - 1)) begin
                filt <= clk_sync[1];
                fcnt <= '0;
            end else
                fcnt <= fcnt + 1'b1;
        end
    end

    assign bit_ev = filt & ~clk_sync[1] & (fcnt == FW'(FILTER_LEN - 1));
    assign sample = dat_sync[1];

    always_ff @(posedge ck) begin
        if (!reset) begin
            state  <= IDLE;
            bitcnt <= '0;
            shreg  <= '0;
            perr   <= 1'b0;
            tcnt   <= '0;
        end else begin
            state  <= state_n;
            bitcnt <= bitcnt_n;
            shreg  <= shreg_n;
            perr   <= perr_n;
            tcnt   <= tcnt_n;
        end
    end

    always_comb begin
        state_n  = state;
        bitcnt_n = bitcnt;
        shreg_n  = shreg;
        perr_n   = perr;
        tcnt_n   = (state != IDLE) ? tcnt + 1'b1 : '0;
        push     = 1'b0;
        tmo_hit  = 1'b0;
        if (bit_ev) begin
            tcnt_n = '0;
            case (state)
                IDLE: if (!sample) begin
                    state_n  = DATA;
                    bitcnt_n = '0;
                    perr_n   = 1'b0;
                end
                DATA: begin
                    shreg_n  = (shreg >> 1) | (DATA_BITS'(sample) << (DATA_BITS - 1));
                    bitcnt_n = bitcnt + 1'b1;
                    if (bitcnt == BW'(DATA_BITS - 1))
                        state_n = (PARITY_EN != 0) ? PARITY : STOP;
                end
                PARITY: begin
                    perr_n  = (^shreg ^ sample) != 1'(PARITY_ODD);
                    state_n = STOP;
                end
                STOP: begin
                    push    = 1'b1;
                    state_n = IDLE;
                end
            endcase
        end else if (state != IDLE && tcnt == TW'(TIMEOUT - 1)) begin
            tmo_hit = 1'b1;
            state_n = IDLE;
        end
        if (state_n == IDLE)
            tcnt_n = '0;
    end

    // A push into a full FIFO still lands when the same cycle frees a slot.
    assign do_rd = rd & ~empty;
    assign do_wr = push & (~full | do_rd);

    always_ff @(posedge ck) begin
        if (do_wr)
            mem[wptr] <= {shreg, perr, ~sample};
    end

    always_ff @(posedge ck) begin
        if (!reset) begin
            wptr    <= '0;
            rptr    <= '0;
            cnt     <= '0;
            overrun <= 1'b0;
            timeout <= 1'b0;
        end else begin
            if (do_wr)
                wptr <= wptr + 1'b1;
            if (do_rd)
                rptr <= rptr + 1'b1;
            cnt     <= cnt + CW'(do_wr) - CW'(do_rd);
            overrun <= push & ~do_wr;
            timeout <= tmo_hit;
        end
    end

    assign head       = mem[rptr];
    assign empty      = (cnt == '0);
    assign full       = (cnt == CW'(FIFO_DEPTH));
    assign count      = cnt;
    assign busy       = (state != IDLE);
    assign rd_data    = empty ? '0 : head[EW-1:2];
    assign rd_par_err = ~empty & head[1];
    assign rd_frm_err = ~empty & head[0];
endmodule

// File: tb/tb_usb_frame_rx.sv
// tb_usb_frame_rx: randomized and directed checks of usb_frame_rx against a queue-based model.
module tb_usb_frame_rx;
    localparam int DEPTH = 4;
    localparam int HALF  = 20;

    logic       ck = 0, reset = 0, ser_clk = 1, ser_data = 1, rd = 0;
    logic [7:0] rd_data;
    logic       rd_par_err, rd_frm_err, empty, full, busy, overrun, timeout;
    logic [2:0] count;

    usb_frame_rx dut (
        .ck(ck), .reset(reset), .ser_clk(ser_clk), .ser_data(ser_data), .rd(rd),
        .rd_data(rd_data), .rd_par_err(rd_par_err), .rd_frm_err(rd_frm_err),
        .empty(empty), .full(full), .count(count), .busy(busy),
        .overrun(overrun), .timeout(timeout)
    );

    always #1 ck = ~ck;

    int checks = 0, failures = 0;
    int n_ovr = 0, n_tmo = 0, exp_ovr = 0;
    logic [9:0] q[$];

    always @(negedge ck) begin
        if (overrun === 1'b1) n_ovr++;
        if (timeout === 1'b1) n_tmo++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge ck);
    endtask

    task automatic send_bit(input logic b, input bit gl);
        ser_data = b;
        if (gl) begin
            cyc(8); ser_clk = 0; cyc(2); ser_clk = 1; cyc(10);
        end else
            cyc(HALF);
        ser_clk = 0;
        cyc(HALF);
        ser_clk = 1;
    endtask

    function automatic logic good_par(input logic [7:0] d);
        return ~(^d);
    endfunction

    task automatic frame(input logic [7:0] d, input logic p, input logic s, input bit gl);
        send_bit(1'b0, gl);
        for (int i = 0; i < 8; i++) send_bit(d[i], gl);
        send_bit(p, gl);
        send_bit(s, gl);
        cyc(10);
        if (q.size() < DEPTH) q.push_back({d, ((^d) ^ p) != 1'b1, ~s});
        else exp_ovr++;
    endtask

    task automatic check_head(input string tag);
        check({tag, "_empty"}, empty, q.size() == 0);
        check({tag, "_count"}, count, q.size());
        check({tag, "_full"}, full, q.size() == DEPTH);
        if (q.size() != 0) begin
            check({tag, "_data"}, rd_data, q[0][9:2]);
            check({tag, "_perr"}, rd_par_err, q[0][1]);
            check({tag, "_ferr"}, rd_frm_err, q[0][0]);
        end
    endtask

    task automatic pop(input string tag);
        check_head(tag);
        rd = 1; cyc(1); rd = 0;
        if (q.size() != 0) void'(q.pop_front());
    endtask

    initial begin
        int t0;
        cyc(3);
        check("rst_data", rd_data, 0);
        check("rst_perr", rd_par_err, 0);
        check("rst_ferr", rd_frm_err, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_count", count, 0);
        check("rst_busy", busy, 0);
        check("rst_ovr", overrun, 0);
        check("rst_tmo", timeout, 0);
        reset = 1;
        cyc(5);

        rd = 1; cyc(1); rd = 0; cyc(1);
        check("rd_empty_count", count, 0);

        frame(8'h6D, 1'b0, 1'b1, 0);
        check("good_busy", busy, 0);
        pop("good");
        frame(8'h6D, 1'b1, 1'b1, 0);
        pop("badpar");
        frame(8'h6D, 1'b0, 1'b0, 0);
        pop("badstop");
        check_head("after3");

        t0 = n_tmo;
        send_bit(1'b0, 0);
        for (int i = 0; i < 4; i++) send_bit(1'(i & 1), 0);
        cyc(3900);
        check("tmo_early_busy", busy, 1);
        check("tmo_early_cnt", n_tmo - t0, 0);
        cyc(200);
        check("tmo_cnt", n_tmo - t0, 1);
        check("tmo_busy", busy, 0);
        check("tmo_empty", empty, 1);
        frame(8'hA5, good_par(8'hA5), 1'b1, 0);
        pop("post_tmo");

        t0 = n_ovr;
        for (int i = 1; i <= 4; i++) frame(8'(i), good_par(8'(i)), 1'b1, 0);
        check("fill_ovr", n_ovr - t0, 0);
        frame(8'h05, good_par(8'h05), 1'b1, 0);
        check("ovr_cnt", n_ovr - t0, 1);
        check("ovr_full", full, 1);
        check("ovr_count", count, 4);
        for (int i = 0; i < 4; i++) pop("drain");
        check_head("drained");

        for (int i = 0; i < 5; i++) begin
            ser_clk = 0; cyc(2); ser_clk = 1; cyc(15);
        end
        check("glitch_busy", busy, 0);
        check("glitch_empty", empty, 1);
        frame(8'h3C, good_par(8'h3C), 1'b1, 1);
        pop("glitch");

        frame(8'h11, good_par(8'h11), 1'b1, 0);
        frame(8'h22, good_par(8'h22), 1'b1, 0);
        check("pre_rst_count", count, 2);
        send_bit(1'b0, 0);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 0);
        reset = 0; cyc(1); reset = 1;
        q.delete();
        cyc(1);
        check("mid_rst_empty", empty, 1);
        check("mid_rst_count", count, 0);
        check("mid_rst_busy", busy, 0);
        frame(8'h96, good_par(8'h96), 1'b1, 0);
        pop("post_rst");

        for (int n = 0; n < 30; n++) begin
            logic [7:0] d;
            logic p, s;
            d = 8'($urandom);
            p = ($urandom_range(0, 3) == 0) ? ~good_par(d) : good_par(d);
            s = ($urandom_range(0, 9) != 0);
            frame(d, p, s, $urandom_range(0, 3) == 0);
            repeat ($urandom_range(0, 2)) pop("rnd");
        end
        while (q.size() != 0) pop("rnd_drain");
        check_head("final");
        check("ovr_total", n_ovr, exp_ovr);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
